mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous main memory between the CPU instruction-fetch path (I port) and the load/store path (D port).
- Each requester uses a req/gnt handshake followed by an rvalid response. The block drives the RAM port directly.
- Sits between the CPU core and the 4096-word MEM array, so the core can issue loads and stores without a second RAM port.

Parameters:
- ADDR_W, 12, word-address width of the RAM (2^ADDR_W 32-bit words)
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction-fetch request; held with i_addr until i_gnt
- i_addr  in  32  byte address; bits [1:0] are ignored
- i_gnt  out  1  I request accepted this cycle
- i_rvalid  out  1  I response valid, one-cycle pulse
- i_rdata  out  32  I read data, valid with i_rvalid
- d_req  in  1  load/store request; held with its fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_wmask  in  4  byte-lane write enables for stores
- d_addr  in  32  byte address; bits [1:0] are ignored
- d_wdata  in  32  store data
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  D response valid; pulses for loads and stores
- d_rdata  out  32  D read data; 0 for stores
- mem_en  out  1  RAM access strobe
- mem_addr  out  ADDR_W  RAM word address
- mem_wmask  out  4  RAM byte write enables; 0 = read
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en
- err  out  1  sticky out-of-range flag; exists only when MEM_ARB_BOUNDS_EN is defined

Behaviour:
- FSM states: IDLE and RESP.
- Reset: state = IDLE, last_owner = D (so I wins the first tie).
- Reset values of all outputs: 0. This covers gnt, rvalid, rdata, mem_en, mem_wmask and err.
- IDLE, no requests: stay in IDLE; mem_en = 0.
- IDLE, one requester asserting req:
  - that requester's gnt = 1 combinationally in the same cycle;
  - mem_en = 1 and mem_addr = addr[ADDR_W+1:2], both combinational;
  - owner is registered; next state = RESP.
- IDLE, both requesting: grant the requester that is not last_owner (round-robin). Update last_owner.
- mem_wmask and mem_wdata:
  - D store: mem_wmask = d_wmask, mem_wdata = d_wdata;
  - D load and all I accesses: mem_wmask = 0, mem_wdata = 0.
- I port never writes.
- RESP:
  - owner's rvalid = 1 and owner's rdata = mem_rdata (0 for a store);
  - no new grant; mem_en = 0;
  - next state = IDLE.
- Latency: gnt to rvalid is exactly 1 cycle.
- Throughput: at most one access per 2 cycles.
- Worst-case wait for a continuously requesting port: 2 cycles before its gnt.
- Requester obligation: req and its fields are held stable until gnt. A requester may drop req before gnt; nothing is issued for it.
- A requester may reassert req in the same cycle as its rvalid. The arbiter considers it in the next IDLE cycle.
- d_wmask = 0 on a store: a RAM cycle is still issued (no bytes change) and d_rvalid still pulses.
- Reset asserted in RESP: the pending rvalid is suppressed and state returns to IDLE.
- Address bits above ADDR_W+1: handling depends on MEM_ARB_BOUNDS_EN (see Optional Feature).

Optional Feature:
- Macro: MEM_ARB_BOUNDS_EN.
- Defined:
  - any nonzero address bit in [31:ADDR_W+2] marks the access out of range;
  - the access is still granted but mem_en stays 0;
  - in RESP, rvalid pulses with rdata = 0;
  - err sets and stays set until reset.
- Undefined: the err port is absent and upper address bits are ignored, so addresses wrap modulo the RAM size.

Decomposition:
- Package mem_arb_pkg:
  - state localparams ST_IDLE = 0, ST_RESP = 1;
  - owner IDs OWN_I = 0, OWN_D = 1;
  - WMASK_NONE = 4'b0000.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: grant one-hot, valid.

Test Plan:
- Single read: after reset, I req addr 0x8 with RAM word 2 = 0x00100093 -> i_gnt in cycle 0 with mem_addr 2 and mem_wmask 0; i_rvalid in cycle 1 with i_rdata 0x00100093.
- Byte store: D store addr 0x11, d_wmask 4'b0010, d_wdata 0x0000AB00 -> mem_addr 4, mem_wmask 0010; d_rvalid the next cycle with d_rdata 0; then a D load of 0x10 returns only byte 1 changed to 0xAB.
- Contention: both req held continuously -> gnt order I, D, I, D on cycles 0, 2, 4, 6; rvalid on cycles 1, 3, 5, 7 to the matching port.
- Abandon: D req raised in RESP of an I access and dropped before IDLE -> no d_gnt, no d_rvalid, mem_en 0.
- Reset in RESP: reset high in the cycle after i_gnt -> i_rvalid stays 0; the next tie grants I.
- Bounds (MEM_ARB_BOUNDS_EN defined): I req addr 0x4000 -> i_gnt, mem_en 0, i_rvalid with i_rdata 0, err 1 until reset. With the macro undefined, the same address reads word 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared encodings for the I/D memory arbiter (FSM states,
//                owner IDs, write-mask constants, small helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // FSM state encodings
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  // Requester identifiers; also used as bit positions in request/grant vectors
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Byte-lane write mask meaning "read access"
  localparam logic [3:0] WMASK_NONE = 4'b0000;

  typedef enum logic {
    IDLE = ST_IDLE,
    RESP = ST_RESP
  } state_t;

  // One-hot grant vector for a given owner ID
  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == OWN_D) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin picker. On a tie the
//                requester that did not own the previous access wins.
//  Revision    : 1.0 - initial release
// ============================================================================
import mem_arb_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       valid
);

  // Pick one requester; ties go to whichever port was not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_owner == OWN_D) ? owner_onehot(OWN_I) : owner_onehot(OWN_D);
      default: grant = 2'b00;
    endcase
    valid = |req;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous RAM between the CPU
//                instruction-fetch (I) and load/store (D) ports using a
//                req/gnt/rvalid handshake. One access per two cycles,
//                gnt-to-rvalid latency of one cycle, round-robin on ties.
//  Options     : MEM_ARB_BOUNDS_EN - flag addresses beyond the RAM with a
//                sticky err output instead of wrapping modulo RAM size.
//  Revision    : 1.0 - initial release
// ============================================================================
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM port
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_BOUNDS_EN
  ,
  output logic              err
`endif
);

  state_t      state;
  state_t      state_nxt;
  logic        owner;          // port being served in RESP
  logic        last_owner;     // port served by the most recent grant
  logic        resp_store;     // RESP belongs to a store: rdata forced to 0
  logic        resp_oor;       // RESP belongs to an out-of-range access

  logic [1:0]  arb_grant;
  logic        arb_valid;
  logic        sel_d;
  logic [31:0] sel_addr;
  logic        sel_store;
  logic        sel_oor;
  logic        unused_addr_bits;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, i_req}),
    .last_owner (last_owner),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign sel_d     = arb_grant[OWN_D];
  assign sel_addr  = sel_d ? d_addr : i_addr;
  assign sel_store = sel_d & d_we;

`ifdef MEM_ARB_BOUNDS_EN
  assign sel_oor          = |sel_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^sel_addr[1:0];
`else
  // Upper address bits are dropped so accesses wrap modulo the RAM size
  assign sel_oor          = 1'b0;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
`endif

  // Next-state and output decode; reset masks grants and suppresses a pending rvalid
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wmask = WMASK_NONE;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (!reset && arb_valid) begin
          i_gnt     = arb_grant[OWN_I];
          d_gnt     = arb_grant[OWN_D];
          mem_en    = !sel_oor;
          mem_addr  = sel_addr[ADDR_W+1:2];
          if (sel_store && !sel_oor) begin
            mem_wmask = d_wmask;
            mem_wdata = d_wdata;
          end
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (!reset) begin
          if (owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = (resp_store || resp_oor) ? '0 : mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = resp_oor ? '0 : mem_rdata;
          end
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-access bookkeeping captured at grant time
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_D;
      resp_store <= 1'b0;
      resp_oor   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_valid) begin
        owner      <= sel_d;
        last_owner <= sel_d;
        resp_store <= sel_store;
        resp_oor   <= sel_oor;
      end
    end
  end

`ifdef MEM_ARB_BOUNDS_EN
  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == IDLE && arb_valid && sel_oor) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
